// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use, taken-branch and multi-cycle
// multiply hazards for the 5-stage MIPS pipe, plus a stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RtAddr_i,
  input  logic [4:0]       IFID_RsAddr_i,
  input  logic [4:0]       IFID_RtAddr_i,
  input  logic             IFID_UsesRt_i,
  input  logic             Branch_i,
  input  logic             EX_MulOp_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXWrite_o,
  output logic             IDEXBubble_o,
  output logic             EXMEMBubble_o,
  output logic             MulBusy_o,
  output logic [CNT_W-1:0] StallCnt_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 2);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_mul_stall;
  logic             w_load_use;
  logic             w_flush;
  logic             w_rs_hit;
  logic             w_rt_hit;

  // IDLE entry counts as the first stall cycle, hence MUL_LAT-2 preload
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mul_stall = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (EX_MulOp_i) begin
          w_mul_stall = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (r_cnt != 4'd0) begin
          w_mul_stall = 1'b1;
          w_cnt_nxt   = r_cnt - 4'd1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (rst_i) begin
      w_mul_stall = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign w_rs_hit = (IDEX_RtAddr_i == IFID_RsAddr_i);
  assign w_rt_hit = IFID_UsesRt_i &&
                    (IDEX_RtAddr_i == IFID_RtAddr_i);

  assign w_load_use = !rst_i && !w_mul_stall &&
                      IDEX_MemRead_i &&
                      (IDEX_RtAddr_i != 5'd0) &&
                      (w_rs_hit || w_rt_hit);

  assign w_flush = !rst_i && Branch_i &&
                   !w_mul_stall && !w_load_use;

  assign PCWrite_o     = !(w_mul_stall || w_load_use);
  assign IFIDWrite_o   = !(w_mul_stall || w_load_use);
  assign IDEXWrite_o   = !w_mul_stall;
  assign IDEXBubble_o  = w_load_use;
  assign EXMEMBubble_o = w_mul_stall;
  assign IFIDFlush_o   = w_flush;
  assign MulBusy_o     = (r_state == S_BUSY) && !rst_i;
  assign StallCnt_o    = r_stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (!PCWrite_o && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS datapath.
- Decides each cycle whether PC, IF/ID and ID/EX advance, hold, bubble or flush, based on:
  - load-use hazards;
  - taken branches resolved in ID;
  - a multi-cycle multiply occupying the EX-stage ALU.
- Sits beside the ID-stage decoder; its outputs drive the pipeline-register enables and the control-zeroing muxes.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
MUL_LAT, 4, total EX-stage occupancy in cycles of a multiply instruction; legal range 2..16
CNT_W, 16, width of stall performance counter

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous active-high reset
IDEX_MemRead_i  in  1  instruction in ID/EX is a load
IDEX_RtAddr_i  in  5  load destination register in ID/EX
IFID_RsAddr_i  in  5  rs field of instruction in IF/ID
IFID_RtAddr_i  in  5  rt field of instruction in IF/ID
IFID_UsesRt_i  in  1  IF/ID instruction reads rt as a source (R-type, beq, sw)
Branch_i  in  1  branch in ID resolved taken this cycle
EX_MulOp_i  in  1  instruction currently in EX is a multiply
PCWrite_o  out  1  PC load enable
IFIDWrite_o  out  1  IF/ID load enable
IFIDFlush_o  out  1  clear IF/ID to nop at next edge
IDEXWrite_o  out  1  ID/EX load enable
IDEXBubble_o  out  1  zero RegWrite/MemRead/MemWrite/Branch into ID/EX
EXMEMBubble_o  out  1  zero control fields into EX/MEM
MulBusy_o  out  1  registered; 1 while FSM in MUL_BUSY
StallCnt_o  out  CNT_W  stall-cycle count, saturating

Behaviour:
- Reset (rst_i=1 at edge):
  - state<=IDLE, cnt<=0, StallCnt_o<=0.
  - While rst_i=1, outputs are forced to: PCWrite_o=1, IFIDWrite_o=1, IDEXWrite_o=1, all bubble/flush outputs=0, MulBusy_o=0.
  - Reset mid-multiply abandons the count; FSM is IDLE next cycle.
- Default outputs (no hazard): PCWrite=1, IFIDWrite=1, IDEXWrite=1, IFIDFlush=0, IDEXBubble=0, EXMEMBubble=0.
- All non-registered outputs are combinational from state, cnt and the current inputs (Mealy); they act in the same cycle.
- FSM, two states; cnt is a 4-bit down-counter:
  - IDLE, EX_MulOp_i=1: mul_stall=1, cnt<=MUL_LAT-2, go MUL_BUSY.
  - MUL_BUSY, cnt!=0: mul_stall=1, cnt<=cnt-1.
  - MUL_BUSY, cnt==0: mul_stall=0 (release cycle), go IDLE. The multiply leaves EX at this edge.
  - Result: a multiply occupies EX exactly MUL_LAT cycles, with MUL_LAT-1 stall cycles.
  - Back-to-back multiplies: the second is detected in IDLE on the following cycle.
  - EX_MulOp_i is ignored while in MUL_BUSY.
- mul_stall effect:
  - PCWrite=0, IFIDWrite=0, IDEXWrite=0, EXMEMBubble=1.
  - Load-use detection and branch flush are both suppressed; ID is frozen and re-evaluated after release.
- Load-use hazard, evaluated only when mul_stall=0. Condition:
  - IDEX_MemRead_i=1, and IDEX_RtAddr_i!=0, and
  - (IDEX_RtAddr_i==IFID_RsAddr_i, or (IFID_UsesRt_i=1 and IDEX_RtAddr_i==IFID_RtAddr_i)).
  - Effect: PCWrite=0, IFIDWrite=0, IDEXBubble=1, for one cycle only. The next cycle the load has left ID/EX.
- Branch flush:
  - IFIDFlush=1 iff Branch_i=1 and mul_stall=0 and load-use=0.
  - PC still writes (the branch target is selected by the datapath).
- Priority: mul_stall > load-use > branch flush > default.
- StallCnt_o:
  - Increments by 1 at each edge where PCWrite_o=0 and rst_i=0.
  - Holds at 2^CNT_W-1 (no wrap).

Test Plan:
- rst_i=1 for 2 cycles with EX_MulOp_i=1 -> PCWrite_o=1, MulBusy_o=0, StallCnt_o=0 after release.
- Load x into $8 (IDEX_MemRead_i=1, IDEX_RtAddr_i=8), IFID_RsAddr_i=8 -> exactly 1 cycle of PCWrite_o=0, IFIDWrite_o=0, IDEXBubble_o=1; StallCnt_o=1. Repeat with RtAddr=0 -> no stall.
- Load to $9, IFID_RtAddr_i=9: with IFID_UsesRt_i=0 -> no stall; with IFID_UsesRt_i=1 -> 1-cycle stall.
- EX_MulOp_i=1 pulse, MUL_LAT=4 -> PCWrite_o=0 and EXMEMBubble_o=1 for 3 cycles, MulBusy_o high for cycles 2-4, release on 4th; StallCnt_o=3. Back-to-back multiplies -> 6 stall cycles total.
- Branch_i=1 concurrent with mul_stall or load-use -> IFIDFlush_o=0 during stall; asserted once the stall clears if Branch_i is still 1.
- Preload StallCnt_o near saturation (CNT_W=4, 16 stall cycles) -> holds at 15.
- Assert rst_i during cycle 2 of a multiply -> IDLE next cycle, PCWrite_o=1, MulBusy_o=0.
